// File: rtl/seg_display_scan.sv
// Four-digit multiplexed seven-segment driver for the stopwatch time value.
// Scans one common-anode digit per refresh slot and blinks the adjusted field.
module seg_display_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min1,
    input  logic [3:0] min0,
    input  logic [3:0] sec1,
    input  logic [3:0] sec0,
    input  logic       adjust,
    input  logic       select,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);
    localparam int RC_W = $clog2(REFRESH_DIV);
    localparam int BC_W = $clog2(BLINK_DIV);
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(REFRESH_DIV - 1);
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(BLINK_DIV - 1);

    logic [RC_W-1:0] rc;
    logic [1:0]      idx;
    logic [BC_W-1:0] bc;
    logic            ph;
    logic [3:0]      sh_min1, sh_min0, sh_sec1, sh_sec0;
    logic            frame_end;
    logic [3:0]      digit;
    logic            blank;
    logic [6:0]      seg_next;
    logic [3:0]      an_next;
    logic            dp_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign frame_end = (rc == RC_MAX) && (idx == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rc  <= '0;
            idx <= 2'd0;
        end else if (rc == RC_MAX) begin
            rc  <= '0;
            idx <= idx + 2'd1;
        end else begin
            rc <= rc + RC_W'(1);
        end
    end

    // Snapshot on the same edge idx wraps to 0, so a frame never mixes two time values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_min1 <= 4'd0;
            sh_min0 <= 4'd0;
            sh_sec1 <= 4'd0;
            sh_sec0 <= 4'd0;
        end else if (frame_end) begin
            sh_min1 <= min1;
            sh_min0 <= min0;
            sh_sec1 <= sec1;
            sh_sec0 <= sec0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bc <= '0;
            ph <= 1'b0;
        end else if (!adjust) begin
            bc <= '0;
            ph <= 1'b0;
        end else if (bc == BC_MAX) begin
            bc <= '0;
            ph <= ~ph;
        end else begin
            bc <= bc + BC_W'(1);
        end
    end

    always_comb begin
        digit = sh_sec0;
        case (idx)
            2'd0:    digit = sh_sec0;
            2'd1:    digit = sh_sec1;
            2'd2:    digit = sh_min0;
            default: digit = sh_min1;
        endcase
        // idx[1] separates the seconds pair (0,1) from the minutes pair (2,3).
        blank    = adjust && ph && (select ? !idx[1] : idx[1]);
        an_next  = 4'b1111;
        seg_next = 7'b1111111;
        dp_next  = 1'b1;
        if (!blank) begin
            an_next[idx] = 1'b0;
            seg_next     = decode(digit);
            dp_next      = (idx != 2'd2);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with REFRESH_DIV=4, BLINK_DIV=8: the driver
// pushes hand-derived per-edge outputs into exp_q, the monitor pops and compares.
module tb_seg_display_scan;

    logic       clk;
    logic       reset;
    logic [3:0] min1, min0, sec1, sec0;
    logic       adjust;
    logic       select;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    seg_display_scan #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .min1   (min1),
        .min0   (min0),
        .sec1   (sec1),
        .sec0   (sec0),
        .adjust (adjust),
        .select (select),
        .seg    (seg),
        .an     (an),
        .dp     (dp)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [11:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int e = 0;            // edge number since last reset release
    logic run = 1'b0;
    logic adj_on = 1'b0;  // bench copy of adjust applied to the edge being predicted
    logic sel_on = 1'b0;
    int adj_start = 0;    // first edge that sampled adjust = 1

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
        7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
    };

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    // Hand table of displayed digits per frame: frame 0 is post-reset zeros,
    // frame 1 is 1,2,3,4, frames 2+ are sec0=5 and min1=12.
    function automatic logic [3:0] frame_digit(input int f, input int idx);
        logic [3:0] f1 [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
        logic [3:0] f2 [4] = '{4'd5, 4'd3, 4'd2, 4'd12};
        if (f == 0) return 4'd0;
        if (f == 1) return f1[idx];
        return f2[idx];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc();
        int idx;
        int f;
        logic blank;
        logic [3:0] an_v;
        e++;
        idx = ((e - 1) / 4) % 4;
        f = (e - 1) / 16;
        blank = adj_on && (((e - adj_start) % 16) >= 8) && (sel_on ? (idx < 2) : (idx >= 2));
        an_v = 4'b1111;
        if (blank) begin
            exp_q.push_back({4'b1111, 7'b1111111, 1'b1});
        end else begin
            an_v[idx] = 1'b0;
            exp_q.push_back({an_v, seg_tab[frame_digit(f, idx)], (idx == 2) ? 1'b0 : 1'b1});
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_an", {8'd0, an}, 12'h00F);
        chk("rst_seg", {5'd0, seg}, 12'h07F);
        chk("rst_dp", {11'd0, dp}, 12'h001);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold_an", {8'd0, an}, 12'h00F);
        chk("rst_hold_seg", {5'd0, seg}, 12'h07F);
        @(negedge clk);
        reset = 1'b0;
        e = 0;
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [11:0] x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("an", {8'd0, an}, {8'd0, x[11:8]});
            chk("seg", {5'd0, seg}, {5'd0, x[7:1]});
            chk("dp", {11'd0, dp}, {11'd0, x[0]});
        end
        if (run) chk("an_onehot", {11'd0, ($countones(~an) <= 1)}, 12'd1);
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        min1 = 4'd1; min0 = 4'd2; sec1 = 4'd3; sec0 = 4'd4;
        adjust = 1'b0;
        select = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("init_an", {8'd0, an}, 12'h00F);
        chk("init_seg", {5'd0, seg}, 12'h07F);
        chk("init_dp", {11'd0, dp}, 12'h001);
        reset = 1'b0;
        run = 1'b1;
        e = 0;

        // Frame 0 shows zeros, frame 1 shows 1,2,3,4; change inputs mid frame 1 (idx 1).
        repeat (21) cyc();
        sec0 = 4'd5;
        min1 = 4'd12;
        repeat (29) cyc();                      // edges 22..50

        // Seconds blink, then move to minutes in the middle of an off phase.
        adjust = 1'b1; select = 1'b1;
        adj_on = 1'b1; sel_on = 1'b1; adj_start = 51;
        repeat (28) cyc();                      // edges 51..78
        select = 1'b0; sel_on = 1'b0;
        repeat (28) cyc();                      // edges 79..106

        // Drop adjust exactly when an off phase would start.
        adjust = 1'b0; adj_on = 1'b0;
        repeat (8) cyc();                       // edges 107..114

        // Minutes blink again; reset lands on idx 2 while it is blanked.
        adjust = 1'b1; adj_on = 1'b1; adj_start = 115;
        repeat (9) cyc();                       // edges 115..123
        select = 1'b1; sel_on = 1'b1; adj_start = 1;
        do_reset();

        // Seconds selected with adjust held: phase restarts visible; reset while visible.
        repeat (6) cyc();
        select = 1'b0; sel_on = 1'b0; adj_start = 1;
        do_reset();

        // One full frame of zeros with minutes blanked in the second half.
        repeat (16) cyc();

        @(posedge clk);
        #2;
        chk("queue_drain", 12'(exp_q.size()), 12'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Four-digit multiplexed seven-segment driver for the stopwatch's BCD time value (min1, min0, sec1, sec0). It sits directly downstream of the stopwatch counter and drives the board's common-anode display: it scans one digit at a time, decodes BCD to active-low segments and lights the colon decimal point. In adjust mode it blinks the digit pair currently selected for adjustment.

## Interface
- REFRESH_DIV, 100000: clk cycles each digit stays enabled; must be at least 2.
- BLINK_DIV, 25000000: clk cycles per blink half-period in adjust mode; must be at least 2.
- clk  input  1  system clock; all state is updated on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- min1, min0, sec1, sec0  input  4 each  BCD digits from the counter; values 10–15 are legal and display blank.
- adjust  input  1  adjust mode enable; synchronous to clk.
- select  input  1  adjusted field: 1 = seconds, 0 = minutes; synchronous to clk.
- seg  output  7  active-low segments, seg[0]=a … seg[6]=g.
- an  output  4  active-low anode enables; an[0]=sec0, an[1]=sec1, an[2]=min0, an[3]=min1.
- dp  output  1  active-low decimal point.

## Operation
- Refresh counter rc:
  - counts 0 … REFRESH_DIV-1, then wraps to 0.
  - When rc = REFRESH_DIV-1, scan index idx advances 0→1→2→3→0.
- Shadow registers:
  - Snapshot of all four inputs, loaded on the edge where rc = REFRESH_DIV-1 and idx = 3, i.e. the same edge on which idx wraps to 0.
  - Every frame therefore shows one coherent time value; input changes mid-frame never tear.
- Digit mux: idx 0/1/2/3 selects shadow sec0/sec1/min0/min1.
- Decode, active-low, bit order g…a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10–15 = 1111111
- dp = 0 only when idx = 2 and that digit is not blanked; otherwise 1.
- Blink counter bc and blink phase ph:
  - adjust = 0: bc and ph clear to 0 on the next edge; no blanking occurs.
  - adjust = 1: bc counts 0 … BLINK_DIV-1; when bc = BLINK_DIV-1 it wraps to 0 and ph toggles.
- Blanking:
  - Active when adjust = 1 and ph = 1.
  - select = 1 blanks idx 0–1; select = 0 blanks idx 2–3.
  - A blanked digit drives an bit = 1, seg = 1111111, dp = 1.
  - select changes take effect on the next output update, with no restart of the blink counter.
- At most one an bit is 0 at any time. Never drive two anodes together.

## Timing
- seg, an and dp are registered and reflect idx, shadow, ph, adjust and select as sampled at the previous edge, so output latency is 1 cycle behind an idx change.
- Reset (asynchronous, immediate):
  - rc = 0, idx = 0, bc = 0, ph = 0, shadows = 0.
  - an = 1111, seg = 1111111, dp = 1.
- First edge after reset release: an = 1110, seg = 1000000 (digit 0), dp = 1.
- Each digit is enabled for exactly REFRESH_DIV cycles; a full frame is 4·REFRESH_DIV cycles.
- The first new snapshot appears on outputs one cycle after the frame-boundary edge.
- After adjust rises, ph stays 0 (digits visible) for BLINK_DIV cycles, then blanks for BLINK_DIV cycles, repeating.
- Reset asserted mid-frame or mid-blink returns every register to its reset value immediately; scanning restarts at idx 0.

## Test plan
Use REFRESH_DIV=4, BLINK_DIV=8.
- Reset release with inputs 1,2,3,4 (min1, min0, sec1, sec0) -> first frame shows 0000: an cycles 1110, 1101, 1011, 0111, each for 4 cycles. Second frame shows sec0=4 (seg 0011001), sec1=3 (0110000), min0=2 (0100100, dp = 0), min1=1 (1111001).
- Change sec0 from 4 to 5 while idx = 1 -> the current frame still shows 4 on an[0]. The next frame shows 5 (0010010) on an[0].
- Input min1 = 12 -> an[3] active with seg = 1111111. Exactly one an bit is 0 every cycle.
- adjust = 1, select = 1 -> an[0] and an[1] stay 1 for 8 cycles out of every 16, starting 8 cycles after adjust rises. Minutes digits are unaffected.
- Switch select to 0 mid-blink -> minutes digits (and dp) blank in the same phases; seconds digits are continuously shown. Dropping adjust clears blanking on the next frame slot.
- Assert reset during idx = 2 of a blink-off phase -> an = 1111 and seg = 1111111 immediately. After release, idx 0 is shown with value 0 and no blanking.
